// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle plus the control-register outputs and event pulses of the
// register peripheral. The controller/testbench side uses master, the peripheral uses slave.
interface spi_reg_peripheral_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe, frame_err
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe, frame_err
  );
endinterface

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 peripheral: synchronises the SPI pins into clk, shifts
// 16-bit frames {rw, addr[6:0], data[7:0]} and commits writes into five 8-bit
// control registers feeding the PWM and output-enable logic.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_peripheral_if.slave  bus
);

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = int'(MAX_ADDR) + 1;
  localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  // sclk and ncs carry one extra stage beyond the synchroniser for edge detection
  logic [SYNC_STAGES:0]   sclk_q, sclk_d;
  logic [SYNC_STAGES:0]   ncs_q, ncs_d;
  logic [SYNC_STAGES-1:0] copi_q, copi_d;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];
  logic                    wr_strobe_q, wr_strobe_d;
  logic                    frame_err_q, frame_err_d;

  logic              sclk_rise;
  logic              ncs_rise;
  logic              ncs_fall;
  logic              copi_s;
  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;

  // Synchroniser chains: new sample enters at bit 0
  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-1:0], bus.sclk};
    ncs_d  = {ncs_q[SYNC_STAGES-1:0], bus.ncs};
    copi_d = {copi_q[SYNC_STAGES-2:0], bus.copi};
  end

  // Edge detects and frame field decode; copi has the sclk depth so data lines up with the edge
  always_comb begin
    sclk_rise  = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    ncs_rise   = ncs_q[SYNC_STAGES-1] & ~ncs_q[SYNC_STAGES];
    ncs_fall   = ~ncs_q[SYNC_STAGES-1] & ncs_q[SYNC_STAGES];
    copi_s     = copi_q[SYNC_STAGES-1];
    frame_rw   = shift_q[FRAME_BITS-1];
    frame_addr = shift_q[DATA_W +: ADDR_W];
    frame_data = shift_q[DATA_W-1:0];
  end

  // Next-state: frame capture, commit decision at chip-select release
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // ncs release has priority over a coincident sclk edge; that bit is dropped
        if (ncs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            if (frame_rw && (frame_addr <= MAX_ADDR)) begin
              wr_strobe_d = 1'b1;
              for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (frame_addr == ADDR_W'(i)) regs_d[i] = frame_data;
              end
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q < CNT_W'(FRAME_BITS)) shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and synchronisers; ncs chain resets to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '0;
      ncs_q       <= '1;
      copi_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      sclk_q      <= sclk_d;
      ncs_q       <= ncs_d;
      copi_q      <= copi_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.en_reg_out_7_0  = regs_q[0];
  assign bus.en_reg_out_15_8 = regs_q[1];
  assign bus.en_reg_pwm_7_0  = regs_q[2];
  assign bus.en_reg_pwm_15_8 = regs_q[3];
  assign bus.pwm_duty_cycle  = regs_q[4];
  assign bus.wr_strobe       = wr_strobe_q;
  assign bus.frame_err       = frame_err_q;

endmodule
